// File: rtl/tone_gen_poly_if.sv
// Key/octave inputs and tone/status outputs of the polyphonic-key tone generator.
interface tone_gen_poly_if #(
    parameter int KEYS = 8
) ();
    logic [KEYS-1:0] keys;
    logic [1:0]      octave;
    logic            tone;
    logic            playing;
    logic [2:0]      note;

    modport master (
        output keys,
        output octave,
        input  tone,
        input  playing,
        input  note
    );

    modport slave (
        input  keys,
        input  octave,
        output tone,
        output playing,
        output note
    );
endinterface

// File: rtl/tone_gen_poly.sv
// Square-wave tone generator: highest pressed key picks a C4..C5 note, octave shifts it up,
// and pitch/key changes only take effect at half-period boundaries.
//   state | meaning
//   IDLE  | silent, tone low, waiting for any key
//   PLAY  | counting half-periods, tone toggling at each boundary
module tone_gen_poly #(
    parameter int INPUT = 50000000,
    parameter int WIDTH = 24,
    parameter int KEYS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    tone_gen_poly_if.slave      bus
);
    localparam int W1 = WIDTH + 1;

    localparam logic IDLE = 1'b0;
    localparam logic PLAY = 1'b1;

    // Half-period length (HP+1) per note; held one bit wider so the octave shift never overflows.
    localparam logic [W1-1:0] HP1 [8] = '{
        W1'(INPUT / 262 / 2), W1'(INPUT / 294 / 2), W1'(INPUT / 330 / 2), W1'(INPUT / 349 / 2),
        W1'(INPUT / 392 / 2), W1'(INPUT / 440 / 2), W1'(INPUT / 494 / 2), W1'(INPUT / 523 / 2)
    };
    localparam logic [W1-1:0] ONE_W1 = W1'(1);

    generate
        if (KEYS < 1 || KEYS > 8) begin : g_bad_keys
            $error("tone_gen_poly: KEYS must be in 1..8");
        end
        if (longint'(INPUT / 262 / 2) - 1 > (longint'(1) << WIDTH) - 1) begin : g_bad_width
            $error("tone_gen_poly: lowest note half-period does not fit in WIDTH bits");
        end
    endgenerate

    logic             state;
    logic             tone;
    logic             playing;
    logic [2:0]       note;
    logic [WIDTH-1:0] cnt;

    logic [2:0]       sel;
    logic             any_key;
    logic [W1-1:0]    shifted;
    logic [WIDTH-1:0] reload;

    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < KEYS; i++) begin
            if (bus.keys[i]) begin
                sel = 3'(i);
            end
        end
    end

    assign any_key = |bus.keys;
    assign shifted = HP1[sel] >> bus.octave;
    assign reload  = (shifted == '0) ? '0 : WIDTH'(shifted - ONE_W1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tone    <= 1'b0;
            playing <= 1'b0;
            note    <= 3'd0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_key) begin
                        cnt     <= reload;
                        note    <= sel;
                        tone    <= 1'b1;
                        playing <= 1'b1;
                        state   <= PLAY;
                    end
                end
                PLAY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - WIDTH'(1);
                    end else if (any_key) begin
                        tone <= ~tone;
                        cnt  <= reload;
                        note <= sel;
                    end else begin
                        // Stop only at a boundary so the final half-period is never cut short.
                        tone    <= 1'b0;
                        cnt     <= '0;
                        playing <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tone    = tone;
    assign bus.playing = playing;
    assign bus.note    = note;
endmodule

// File: tb/tb_tone_gen_poly.sv
// Scoreboard bench: stimulus queues each expected output change (with its spacing in cycles),
// a negedge monitor pops and compares whenever tone/playing/note change.
module tb_tone_gen_poly;
    typedef struct {
        logic       tone;
        logic       playing;
        logic [2:0] note;
        int         gap;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   ev_idx = 0;
    bit   mon_en = 1'b0;
    logic [4:0] prev;
    ev_t  expq[$];

    tone_gen_poly_if #(.KEYS(8)) bus ();

    tone_gen_poly #(.INPUT(8800), .WIDTH(8), .KEYS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [4:0] cur;
        ev_t e;
        int gap;
        cur = {bus.tone, bus.playing, bus.note};
        if (mon_en && cur !== prev) begin
            gap = cyc - last_cyc;
            last_cyc = cyc;
            ev_idx++;
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event%0d: got tone=%0b playing=%0b note=%0d gap=%0d, none expected",
                         ev_idx, bus.tone, bus.playing, bus.note, gap);
            end else begin
                e = expq.pop_front();
                if (bus.tone !== e.tone || bus.playing !== e.playing || bus.note !== e.note ||
                    (e.gap >= 0 && gap != e.gap)) begin
                    failures++;
                    $display("FAIL event%0d: got tone=%0b playing=%0b note=%0d gap=%0d, expected tone=%0b playing=%0b note=%0d gap=%0d",
                             ev_idx, bus.tone, bus.playing, bus.note, gap, e.tone, e.playing, e.note, e.gap);
                end
            end
        end
        prev = cur;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic t, input logic p, input logic [2:0] n, input int g);
        ev_t e;
        e.tone = t; e.playing = p; e.note = n; e.gap = g;
        expq.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (expq.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: %0d events still pending, required 0", name, expq.size());
            expq.delete();
        end
        tick(15);
    endtask

    initial begin
        rst = 1'b1;
        bus.keys = 8'h00;
        bus.octave = 2'd0;
        tick(3);
        checks++;
        if ({bus.tone, bus.playing, bus.note} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state: got tone=%0b playing=%0b note=%0d, required 0 0 0",
                     bus.tone, bus.playing, bus.note);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        tick(3);
        checks++;
        if ({bus.tone, bus.playing} !== 2'b0) begin
            failures++;
            $display("FAIL idle_no_keys: got tone=%0b playing=%0b, required 0 0", bus.tone, bus.playing);
        end

        // A4 held: 10-cycle half-periods, released 3 cycles into a high half
        bus.keys = 8'h20;
        push(1, 1, 5, -1);
        push(0, 1, 5, 10);
        push(1, 1, 5, 10);
        push(0, 1, 5, 10);
        push(1, 1, 5, 10);
        push(0, 0, 5, 10);
        tick(44);
        bus.keys = 8'h00;
        drain("a4_held", 40);

        // C4+A4: A4 wins; a release/re-press between boundaries is ignored
        bus.keys = 8'h21;
        push(1, 1, 5, -1);
        push(0, 1, 5, 10);
        push(1, 1, 5, 10);
        push(0, 0, 5, 10);
        tick(3);
        bus.keys = 8'h00;
        tick(2);
        bus.keys = 8'h21;
        tick(20);
        bus.keys = 8'h00;
        drain("priority", 40);

        // A4 -> C4 mid half-period; release during a low half
        bus.keys = 8'h20;
        push(1, 1, 5, -1);
        push(0, 1, 0, 10);
        push(1, 1, 0, 16);
        push(0, 1, 0, 16);
        push(0, 0, 0, 16);
        tick(4);
        bus.keys = 8'h01;
        tick(41);
        bus.keys = 8'h00;
        drain("note_switch", 60);

        // Octave 1 then 3: half-period 5, then 1 cycle
        bus.octave = 2'd1;
        bus.keys = 8'h20;
        push(1, 1, 5, -1);
        push(0, 1, 5, 5);
        push(1, 1, 5, 5);
        push(0, 1, 5, 5);
        push(1, 1, 5, 1);
        push(0, 1, 5, 1);
        push(1, 1, 5, 1);
        push(0, 0, 5, 1);
        tick(12);
        bus.octave = 2'd3;
        tick(7);
        bus.keys = 8'h00;
        bus.octave = 2'd0;
        drain("octave", 30);

        // Reset mid high half with key held, then full restart
        bus.keys = 8'h20;
        push(1, 1, 5, -1);
        push(0, 0, 0, 4);
        push(1, 1, 5, 1);
        push(0, 1, 5, 10);
        push(0, 0, 5, 10);
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(13);
        bus.keys = 8'h00;
        drain("reset_mid", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tone_gen_poly.md
TONE_GEN_POLY -- requirements
Module: tone_gen_poly

Interface
REQ-001 SHALL have parameter INPUT, default 50000000: input clock frequency in Hz.
REQ-002 SHALL have parameter WIDTH, default 24: half-period counter width in bits.
REQ-003 SHALL have parameter KEYS, default 8: number of key inputs, legal range 1..8.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port keys  input  KEYS  key-pressed level per note; bit i selects note i.
REQ-007 SHALL have port octave  input  2  upward octave shift, 0..3.
REQ-008 SHALL have port tone  output  1  square-wave audio output, registered.
REQ-009 SHALL have port playing  output  1  high while the FSM is in PLAY, registered.
REQ-010 SHALL have port note  output  3  index of the note currently sounding, registered.

Function
REQ-011 SHALL use a fixed note table with index 0..7 = 262, 294, 330, 349, 392, 440, 494, 523 Hz (C4..C5); only indices below KEYS are reachable.
REQ-012 SHALL compute HP[i] = INPUT/FREQ[i]/2 - 1 with integer division evaluated left to right, as elaboration-time constants.
REQ-013 SHALL fail elaboration ($error) if HP[0] > 2^WIDTH-1 or if KEYS is outside 1..8.
REQ-014 SHALL select the highest-index asserted key bit when several keys are asserted at once.
REQ-015 SHALL compute reload = ((HP[sel]+1) >> octave) - 1, clamped to 0 when (HP[sel]+1) >> octave equals 0.
REQ-016 SHALL implement two states: IDLE (tone=0, playing=0) and PLAY (playing=1).
REQ-017 In IDLE, on an edge with keys != 0: cnt <= reload, note <= sel, tone <= 1, state <= PLAY. tone therefore rises one cycle after the key is sampled.
REQ-018 In IDLE with keys == 0, all registers SHALL hold.
REQ-019 In PLAY with cnt != 0: cnt <= cnt-1; tone, note and state SHALL hold. keys and octave SHALL be ignored.
REQ-020 In PLAY with cnt == 0 (half-period boundary) and keys != 0: tone toggles, cnt <= reload, note <= sel. keys and octave are sampled only at this boundary, so pitch changes are glitch-free.
REQ-021 In PLAY with cnt == 0 and keys == 0: tone <= 0, cnt <= 0, state <= IDLE, note holds. The last half-period ends low with no runt pulse.
REQ-022 Each half-period SHALL last exactly reload+1 cycles, giving a full period of 2*(reload+1) cycles.
REQ-023 With reload == 0, tone SHALL toggle every cycle while keys remain asserted.
REQ-024 A key released and re-pressed between boundaries SHALL have no effect.

Reset
REQ-025 While rst is high at a clock edge: state <= IDLE, tone <= 0, playing <= 0, note <= 0, cnt <= 0. Reset overrides all other behaviour, including mid-half-period.
REQ-026 On the first edge after rst falls, normal IDLE behaviour SHALL apply, so a key held through reset starts playing on that edge.

Verification
All scenarios use INPUT=8800, WIDTH=8, KEYS=8, giving HP = 15, 13, 12, 11, 10, 9, 7, 7.
REQ-027 Scenario 1: keys=8'h20, octave=0 held. Required response: tone high 10 cycles and low 10 cycles repeatedly; note=5; playing=1 from the cycle after the press.
REQ-028 Scenario 2: keys=8'h21 (C4 and A4 pressed). Required response: note=5, half-period 10 cycles (A4 wins priority).
REQ-029 Scenario 3: A4 playing, switch keys to 8'h01 mid-half-period. Required response: the current half-period completes at 10 cycles, then half-periods of 16 cycles; note changes to 0 exactly at the boundary.
REQ-030 Scenario 4: keys=8'h20, octave=1, then octave=3. Required response: half-period 5 cycles, then 1 cycle after the next boundary (reload (10>>3)-1 = 0).
REQ-031 Scenario 5: keys released 3 cycles into a high half-period. Required response: tone stays high through cycle 10, then tone=0 and playing=0 together on the same edge; when released during a low half-period, the FSM returns to IDLE at that half-period's end with no extra high pulse.
REQ-032 Scenario 6: rst asserted for 1 cycle mid-high-half-period while a key is held. Required response: tone=0, playing=0, note=0 on the reset edge; playing again on the next edge with tone high for a full 10 cycles.
